fft_core: RTL and testbench

- Clocked, iterative radix-2 FFT over one buffer of real signed samples.
- Accepts a packed bus of samples, runs an in-place decimation-in-frequency FFT with one butterfly per clock, then outputs a packed bus of per-bin magnitudes in natural order.
- Sits between the audio sample buffer and the spectrum/visualisation logic.

---
 rtl/fft_core.sv | 201 ++++++++++++++++++++
 tb/tb_fft_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_core.sv
// Iterative radix-2 decimation-in-frequency FFT over one buffer of real samples.
// One butterfly per clock in place, then per-bin magnitude estimates in natural order.
module fft_core #(
  parameter int sample_size   = 32,
  parameter int buffer_size   = 32,
  parameter int twiddle_size  = 16,
  parameter int no_float_mult = 1000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [sample_size*buffer_size-1:0] input_bitstream,
  output logic [sample_size*buffer_size-1:0] output_bitstream,
  output logic                               busy,
  output logic                               done
);

  localparam int N  = buffer_size;
  localparam int L  = $clog2(N);
  localparam int IW = sample_size + L + 1;
  localparam int TW = twiddle_size;
  localparam int PW = IW + TW + 1;
  localparam int SW = $clog2(L);
  localparam int HB = L - 1;
  localparam int CW = L + 1;

  localparam logic signed [PW-1:0]          M_S    = PW'(no_float_mult);
  localparam logic        [sample_size-1:0] MAGMAX = {1'b0, {(sample_size-1){1'b1}}};

  function automatic logic [N/2*TW-1:0] twiddle_table(input bit imag);
    logic [N/2*TW-1:0] t;
    real               ang;
    int                v;
    t = '0;
    for (int unsigned k = 0; k < N/2; k++) begin
      ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
      if (imag) v = -int'(real'(no_float_mult) * $sin(ang));
      else      v =  int'(real'(no_float_mult) * $cos(ang));
      t[k*TW +: TW] = TW'(v);
    end
    return t;
  endfunction

  localparam logic [N/2*TW-1:0] TW_RE = twiddle_table(1'b0);
  localparam logic [N/2*TW-1:0] TW_IM = twiddle_table(1'b1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_MAG, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [SW-1:0] r_stage;
  logic [HB-1:0] r_bf;
  logic [CW-1:0] r_cnt;
  logic [L-1:0]  r_mk;
  logic [sample_size-1:0] r_mag;
  logic [sample_size*buffer_size-1:0] r_out;

  logic signed [IW-1:0] r_re [N];
  logic signed [IW-1:0] r_im [N];

  // butterfly addressing
  logic [SW-1:0] w_shift;
  logic [L-1:0]  w_span;
  logic [L-1:0]  w_mask;
  logic [L-1:0]  w_bfx;
  logic [L-1:0]  w_j;
  logic [L-1:0]  w_a;
  logic [L-1:0]  w_b;
  logic [HB-1:0] w_k;
  logic          w_last_bf;

  // butterfly datapath
  logic signed [TW-1:0] w_wr, w_wi;
  logic signed [IW-1:0] w_ar, w_ai, w_br, w_bi;
  logic signed [IW-1:0] w_sr, w_si, w_dr, w_di;
  logic signed [PW-1:0] w_pre, w_pim;
  logic signed [IW-1:0] w_nbr, w_nbi;

  // magnitude datapath
  logic [L-1:0]         w_maddr;
  logic signed [IW-1:0] w_mr, w_mi;
  logic [IW-1:0]        w_absr, w_absi, w_max, w_min;
  logic [IW:0]          w_sum;
  logic [sample_size-1:0] w_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  assign w_last_bf = (r_stage == SW'(L-1)) && (r_bf == '1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_COMPUTE;
      S_COMPUTE: if (w_last_bf) w_next = S_MAG;
      S_MAG:     if (r_cnt == CW'(N)) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Stage s pairs elements span=N>>(s+1) apart; the butterfly counter splits
  // into group bits (shifted up past the span bit) and an in-group offset.
  always_comb begin
    w_shift = SW'(L-1) - r_stage;
    w_span  = L'(1) << w_shift;
    w_mask  = w_span - L'(1);
    w_bfx   = {1'b0, r_bf};
    w_j     = w_bfx & w_mask;
    w_a     = ((w_bfx & ~w_mask) << 1) | w_j;
    w_b     = w_a | w_span;
    w_k     = HB'(w_j << r_stage);
  end

  always_comb begin
    w_wr  = TW_RE[w_k*TW +: TW];
    w_wi  = TW_IM[w_k*TW +: TW];
    w_ar  = r_re[w_a];
    w_ai  = r_im[w_a];
    w_br  = r_re[w_b];
    w_bi  = r_im[w_b];
    w_sr  = w_ar + w_br;
    w_si  = w_ai + w_bi;
    w_dr  = w_ar - w_br;
    w_di  = w_ai - w_bi;
    w_pre = PW'(w_dr) * PW'(w_wr) - PW'(w_di) * PW'(w_wi);
    w_pim = PW'(w_dr) * PW'(w_wi) + PW'(w_di) * PW'(w_wr);
    w_nbr = IW'(w_pre / M_S);
    w_nbi = IW'(w_pim / M_S);
  end

  always_comb begin
    w_maddr = '0;
    for (int unsigned i = 0; i < L; i++) w_maddr[i] = r_cnt[L-1-i];
    w_mr   = r_re[w_maddr];
    w_mi   = r_im[w_maddr];
    w_absr = w_mr[IW-1] ? IW'(-w_mr) : w_mr;
    w_absi = w_mi[IW-1] ? IW'(-w_mi) : w_mi;
    w_max  = (w_absr >= w_absi) ? w_absr : w_absi;
    w_min  = (w_absr >= w_absi) ? w_absi : w_absr;
    w_sum  = {1'b0, w_max} + {3'b000, w_min[IW-1:2]};
    w_mag  = (w_sum > (IW+1)'(MAGMAX)) ? MAGMAX : w_sum[sample_size-1:0];
  end

  // Working memory carries no reset; its contents are only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      for (int unsigned n = 0; n < N; n++) begin
        r_re[n] <= IW'(signed'(input_bitstream[n*sample_size +: sample_size]));
        r_im[n] <= '0;
      end
    end else if (r_state == S_COMPUTE) begin
      r_re[w_a] <= w_sr;
      r_im[w_a] <= w_si;
      r_re[w_b] <= w_nbr;
      r_im[w_b] <= w_nbi;
    end
  end

  // MAG is a two-step pipeline: count c reads bin c, count c+1 writes it,
  // so the phase spans N+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
      r_bf    <= '0;
      r_cnt   <= '0;
      r_mk    <= '0;
      r_mag   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_stage <= '0;
            r_bf    <= '0;
            r_cnt   <= '0;
          end
        end
        S_COMPUTE: begin
          r_bf <= r_bf + HB'(1);
          if (r_bf == '1) r_stage <= r_stage + SW'(1);
        end
        S_MAG: begin
          r_cnt <= r_cnt + CW'(1);
          r_mk  <= r_cnt[L-1:0];
          r_mag <= w_mag;
          if (r_cnt != '0) r_out[r_mk*sample_size +: sample_size] <= r_mag;
        end
        default: ;
      endcase
    end
  end

  assign output_bitstream = r_out;
  assign busy             = (r_state == S_COMPUTE) || (r_state == S_MAG);
  assign done             = (r_state == S_DONE);

endmodule

// File: tb/tb_fft_core.sv
// Bench for fft_core: directed vector table, hand-written control sequences,
// and random buffers checked against a floating-point DFT reference.
module tb_fft_core;

  localparam int  SS = 32;
  localparam int  N  = 32;
  localparam real PI = 3.14159265358979323846;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          start = 1'b0;
  logic [SS*N-1:0] din = '0;
  logic [SS*N-1:0] dout;
  logic          busy;
  logic          done;

  int  n_pass = 0;
  int  n_chk  = 0;
  int  n_done = 0;
  int  xs      [N];
  real ref_mag [N];
  int  saved   [N];

  typedef struct {
    string name;
    int    pat;
    int    bin;
    int    lo;
    int    hi;
  } vec_t;
  vec_t tbl [$];

  fft_core #(
    .sample_size  (SS),
    .buffer_size  (N),
    .twiddle_size (16),
    .no_float_mult(1000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .input_bitstream (din),
    .output_bitstream(dout),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) n_done <= n_done + 1;

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
  endtask

  function automatic int bin(input int k);
    return int'(dout[k*SS +: SS]);
  endfunction

  task automatic add_vec(input string name, input int pat, input int b, input int lo, input int hi);
    vec_t v;
    v.name = name; v.pat = pat; v.bin = b; v.lo = lo; v.hi = hi;
    tbl.push_back(v);
  endtask

  task automatic set_pattern(input int p);
    for (int n = 0; n < N; n++) begin
      case (p)
        0:       xs[n] = 100;
        1:       xs[n] = (n == 0) ? 1000 : 0;
        2:       xs[n] = int'(1000.0 * $cos(2.0 * PI * 4.0 * real'(n) / real'(N)));
        3:       xs[n] = $rtoi(10.0 * $sin(real'(n)));
        default: xs[n] = int'($urandom_range(2000, 0)) - 1000;
      endcase
    end
  endtask

  task automatic pack_in();
    for (int n = 0; n < N; n++) din[n*SS +: SS] = xs[n];
  endtask

  // Direct DFT of xs followed by the max + min/4 magnitude estimate.
  task automatic compute_ref();
    real re, im, ar, ai;
    for (int k = 0; k < N; k++) begin
      re = 0.0; im = 0.0;
      for (int n = 0; n < N; n++) begin
        re += real'(xs[n]) * $cos(2.0 * PI * real'(k * n) / real'(N));
        im -= real'(xs[n]) * $sin(2.0 * PI * real'(k * n) / real'(N));
      end
      ar = (re < 0.0) ? -re : re;
      ai = (im < 0.0) ? -im : im;
      ref_mag[k] = (ar >= ai) ? ar + ai / 4.0 : ai + ar / 4.0;
    end
  endtask

  task automatic run_fft(input string tag);
    int lat;
    pack_in();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, longint'(busy), 1, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 113, 113);
    check({tag, "_busy_in_done"}, longint'(busy), 0, 0);
  endtask

  initial begin
    int cur, lat, base, i1, i2, tol, sum_abs, d;

    for (int k = 0; k < N; k++) add_vec("dc", 0, k, (k == 0) ? 3200 : 0, (k == 0) ? 3200 : 0);
    for (int k = 0; k < N; k++) add_vec("impulse", 1, k, 1000, 1000);
    for (int k = 0; k < N; k++)
      if (k == 4 || k == 28) add_vec("tone", 2, k, 15936, 16064);
      else                   add_vec("tone", 2, k, 0, 64);

    // asynchronous reset with no clock edge in between
    #2 rst = 1'b1;
    #1;
    check("reset_out_zero", (dout === '0) ? 0 : 1, 0, 0);
    check("reset_busy", (busy === 1'b0) ? 0 : 1, 0, 0);
    check("reset_done", (done === 1'b0) ? 0 : 1, 0, 0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    base = n_done;
    repeat (10) @(posedge clk);
    #1;
    check("idle_no_done", n_done - base, 0, 0);

    cur = -1;
    foreach (tbl[i]) begin
      if (tbl[i].pat != cur) begin
        cur = tbl[i].pat;
        set_pattern(cur);
        run_fft(tbl[i].name);
      end
      check($sformatf("%s_bin%0d", tbl[i].name, tbl[i].bin), bin(tbl[i].bin), tbl[i].lo, tbl[i].hi);
    end

    // tone symmetry of a real input
    set_pattern(2);
    run_fft("tone2");
    for (int k = 0; k < N; k++) saved[k] = bin(k);
    for (int k = 1; k < N/2; k++) begin
      d = saved[k] - saved[N-k];
      check($sformatf("tone_sym%0d", k), d, -4, 4);
    end

    // sine at 1 rad/sample peaks at bins 5 and 27
    set_pattern(3);
    run_fft("sine");
    i1 = 0;
    for (int k = 1; k < N; k++) if (bin(k) > bin(i1)) i1 = k;
    i2 = (i1 == 0) ? 1 : 0;
    for (int k = 0; k < N; k++) if (k != i1 && bin(k) > bin(i2)) i2 = k;
    check("sine_peak_lo", (i1 < i2) ? i1 : i2, 5, 5);
    check("sine_peak_hi", (i1 < i2) ? i2 : i1, 27, 27);
    check("sine_peak_match", bin(5) - bin(27), -2, 2);
    check("sine_bin0", bin(0), 0, 10);

    // start during a run is ignored
    set_pattern(2);
    pack_in();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 20) begin
        set_pattern(0);
        pack_in();
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("restart_ignored_latency", lat, 113, 113);
    for (int k = 0; k < N; k++) check($sformatf("restart_ignored_bin%0d", k), bin(k), saved[k], saved[k]);

    // reset mid-run aborts, then a clean DC run
    set_pattern(2);
    pack_in();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_zero", (dout === '0) ? 0 : 1, 0, 0);
    check("abort_busy", (busy === 1'b0) ? 0 : 1, 0, 0);
    check("abort_done", (done === 1'b0) ? 0 : 1, 0, 0);
    base = n_done;
    @(negedge clk);
    rst = 1'b0;
    set_pattern(0);
    run_fft("after_abort");
    repeat (4) @(posedge clk);
    #1;
    check("after_abort_bin0", bin(0), 3200, 3200);
    check("after_abort_done_count", n_done - base, 1, 1);

    // random buffers against the DFT reference
    for (int r = 0; r < 6; r++) begin
      set_pattern(4);
      compute_ref();
      sum_abs = 0;
      for (int n = 0; n < N; n++) sum_abs += (xs[n] < 0) ? -xs[n] : xs[n];
      tol = 8 + sum_abs / 128;
      run_fft($sformatf("rand%0d", r));
      for (int k = 0; k < N; k++)
        check($sformatf("rand%0d_bin%0d", r, k), bin(k),
              longint'($rtoi(ref_mag[k])) - tol, longint'($rtoi(ref_mag[k])) + tol);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
